// File: rtl/writeback_pkg.sv
// Shared types and widths for the register-file writeback path.
package writeback_pkg;

    typedef enum logic [2:0] {
        WB_NONE,
        WB_MEMORY,
        WB_ALU,
        WB_IMMEDIATE,
        WB_BRANCH
    } wb_source_t;

    localparam int REG_INDEX_WIDTH = 5;
    localparam int XLEN            = 32;

endpackage

// File: rtl/writeback_rr_picker.sv
// Three-way round-robin pick over alu (0), immediate former (1), branch ALU (2).
module writeback_rr_picker (
    input  logic [2:0] valid,
    input  logic [1:0] ptr,
    output logic [2:0] grant,
    output logic [1:0] next_ptr
);

    logic [3:0] valid_ext;
    logic [3:0] grant_ext;
    logic [2:0] pos;
    logic       found;

    assign valid_ext = {1'b0, valid};
    assign grant     = grant_ext[2:0];

    // Scan from the pointer, wrapping modulo 3; first valid source wins.
    always_comb begin
        grant_ext = '0;
        next_ptr  = ptr;
        found     = 1'b0;
        pos       = '0;
        for (int k = 0; k < 3; k++) begin
            pos = {1'b0, ptr} + 3'(k);
            if (pos >= 3'd3) begin
                pos = pos - 3'd3;
            end
            if (!found && valid_ext[pos[1:0]]) begin
                found               = 1'b1;
                grant_ext[pos[1:0]] = 1'b1;
                next_ptr            = (pos[1:0] == 2'd2) ? 2'd0 : pos[1:0] + 2'd1;
            end
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Single register-file write port arbiter: memory-priority grant with starvation
// relief, round-robin among the rest, and a one-stage registered write.
module writeback_arbiter
    import writeback_pkg::*;
#(
    parameter int MAX_CONSEC = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       writebackStall,
    input  logic                       memoryValid,
    input  logic                       aluValid,
    input  logic                       immediateFormerValid,
    input  logic                       branchALUValid,
    input  logic [REG_INDEX_WIDTH-1:0] memoryRdIndex,
    input  logic [REG_INDEX_WIDTH-1:0] aluRdIndex,
    input  logic [REG_INDEX_WIDTH-1:0] immediateFormerRdIndex,
    input  logic [REG_INDEX_WIDTH-1:0] branchALURdIndex,
    output logic                       memoryReady,
    output logic                       aluReady,
    output logic                       immediateFormerReady,
    output logic                       branchALUReady,
    output logic                       memoryOutputEnable,
    output logic                       aluOutputEnable,
    output logic                       immediateFormerOutputEnable,
    output logic                       branchALUOutputEnable,
    input  logic [XLEN-1:0]            rdIn,
    output logic                       regWriteEnable,
    output logic [REG_INDEX_WIDTH-1:0] regWriteIndex,
    output logic [XLEN-1:0]            regWriteData
);

    localparam int CNT_W = $clog2(MAX_CONSEC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CONSEC);

    logic [1:0]                 ptr_q, ptr_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       reg_we_q, reg_we_d;
    logic [REG_INDEX_WIDTH-1:0] reg_idx_q, reg_idx_d;
    logic [XLEN-1:0]            reg_data_q, reg_data_d;

    logic [2:0]                 rr_valid;
    logic [2:0]                 rr_grant;
    logic [1:0]                 rr_next_ptr;
    logic                       others_valid;
    logic                       starve_override;
    wb_source_t                 grant_src;
    logic [REG_INDEX_WIDTH-1:0] grant_idx;
    logic                       grant_any;

    assign rr_valid        = {branchALUValid, immediateFormerValid, aluValid};
    assign others_valid    = |rr_valid;
    assign starve_override = others_valid && (cnt_q == CNT_MAX);

    writeback_rr_picker u_rr_picker (
        .valid    (rr_valid),
        .ptr      (ptr_q),
        .grant    (rr_grant),
        .next_ptr (rr_next_ptr)
    );

    // Grants are suppressed during reset so the chooser never sees a stray select.
    always_comb begin
        grant_src = WB_NONE;
        if (reset && !writebackStall) begin
            if (memoryValid && !starve_override) begin
                grant_src = WB_MEMORY;
            end else if (rr_grant[0]) begin
                grant_src = WB_ALU;
            end else if (rr_grant[1]) begin
                grant_src = WB_IMMEDIATE;
            end else if (rr_grant[2]) begin
                grant_src = WB_BRANCH;
            end
        end
    end

    assign memoryReady          = (grant_src == WB_MEMORY);
    assign aluReady             = (grant_src == WB_ALU);
    assign immediateFormerReady = (grant_src == WB_IMMEDIATE);
    assign branchALUReady       = (grant_src == WB_BRANCH);

    assign memoryOutputEnable          = memoryReady;
    assign aluOutputEnable             = aluReady;
    assign immediateFormerOutputEnable = immediateFormerReady;
    assign branchALUOutputEnable       = branchALUReady;

    always_comb begin
        case (grant_src)
            WB_MEMORY:    grant_idx = memoryRdIndex;
            WB_ALU:       grant_idx = aluRdIndex;
            WB_IMMEDIATE: grant_idx = immediateFormerRdIndex;
            WB_BRANCH:    grant_idx = branchALURdIndex;
            default:      grant_idx = '0;
        endcase
    end

    assign grant_any = (grant_src != WB_NONE);

    // A stall freezes fairness state; otherwise the counter only survives
    // back-to-back memory wins that actually made someone else wait.
    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (!writebackStall) begin
            if (grant_src == WB_MEMORY) begin
                cnt_d = others_valid ? cnt_q + CNT_W'(1) : '0;
            end else begin
                cnt_d = '0;
            end
            if (grant_any && grant_src != WB_MEMORY) begin
                ptr_d = rr_next_ptr;
            end
        end
    end

    always_comb begin
        reg_we_d   = grant_any && (grant_idx != '0);
        reg_idx_d  = grant_any ? grant_idx : reg_idx_q;
        reg_data_d = grant_any ? rdIn : reg_data_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_q      <= '0;
            cnt_q      <= '0;
            reg_we_q   <= 1'b0;
            reg_idx_q  <= '0;
            reg_data_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            reg_we_q   <= reg_we_d;
            reg_idx_q  <= reg_idx_d;
            reg_data_q <= reg_data_d;
        end
    end

    assign regWriteEnable = reg_we_q;
    assign regWriteIndex  = reg_idx_q;
    assign regWriteData   = reg_data_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a behavioural arbitration model.
module tb_writeback_arbiter;
    import writeback_pkg::*;

    localparam int MAXC = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        writebackStall = 1'b0;
    logic        memoryValid = 1'b0, aluValid = 1'b0, immediateFormerValid = 1'b0, branchALUValid = 1'b0;
    logic [4:0]  memoryRdIndex = '0, aluRdIndex = '0, immediateFormerRdIndex = '0, branchALURdIndex = '0;
    logic        memoryReady, aluReady, immediateFormerReady, branchALUReady;
    logic        memoryOutputEnable, aluOutputEnable, immediateFormerOutputEnable, branchALUOutputEnable;
    logic [31:0] rdIn = '0;
    logic        regWriteEnable;
    logic [4:0]  regWriteIndex;
    logic [31:0] regWriteData;

    int total = 0;
    int bad   = 0;
    bit cmp_on = 1'b0;

    // Model state: round-robin position (0 alu, 1 imm, 2 branch), memory streak, write stage.
    int          m_ptr  = 0;
    int          m_cnt  = 0;
    bit          m_we   = 1'b0;
    int          m_idx  = 0;
    logic [31:0] m_data = '0;
    wb_source_t  mg;
    bit          m_others;

    wb_source_t exp_rr[6]   = '{WB_ALU, WB_IMMEDIATE, WB_BRANCH, WB_ALU, WB_IMMEDIATE, WB_BRANCH};
    wb_source_t exp_mem[6]  = '{WB_MEMORY, WB_MEMORY, WB_MEMORY, WB_MEMORY, WB_ALU, WB_MEMORY};
    wb_source_t src_map[4]  = '{WB_MEMORY, WB_ALU, WB_IMMEDIATE, WB_BRANCH};

    writeback_arbiter #(.MAX_CONSEC(MAXC)) dut (
        .clock                       (clock),
        .reset                       (reset),
        .writebackStall              (writebackStall),
        .memoryValid                 (memoryValid),
        .aluValid                    (aluValid),
        .immediateFormerValid        (immediateFormerValid),
        .branchALUValid              (branchALUValid),
        .memoryRdIndex               (memoryRdIndex),
        .aluRdIndex                  (aluRdIndex),
        .immediateFormerRdIndex      (immediateFormerRdIndex),
        .branchALURdIndex            (branchALURdIndex),
        .memoryReady                 (memoryReady),
        .aluReady                    (aluReady),
        .immediateFormerReady        (immediateFormerReady),
        .branchALUReady              (branchALUReady),
        .memoryOutputEnable          (memoryOutputEnable),
        .aluOutputEnable             (aluOutputEnable),
        .immediateFormerOutputEnable (immediateFormerOutputEnable),
        .branchALUOutputEnable       (branchALUOutputEnable),
        .rdIn                        (rdIn),
        .regWriteEnable              (regWriteEnable),
        .regWriteIndex               (regWriteIndex),
        .regWriteData                (regWriteData)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic wb_source_t rr_src(input int s);
        case (s)
            0:       return WB_ALU;
            1:       return WB_IMMEDIATE;
            default: return WB_BRANCH;
        endcase
    endfunction

    function automatic int rr_pos(input wb_source_t g);
        case (g)
            WB_ALU:       return 0;
            WB_IMMEDIATE: return 1;
            default:      return 2;
        endcase
    endfunction

    function automatic int idx_of(input wb_source_t g);
        case (g)
            WB_MEMORY:    return int'(memoryRdIndex);
            WB_ALU:       return int'(aluRdIndex);
            WB_IMMEDIATE: return int'(immediateFormerRdIndex);
            WB_BRANCH:    return int'(branchALURdIndex);
            default:      return 0;
        endcase
    endfunction

    function automatic wb_source_t model_pick();
        bit rv[3];
        bit others;
        rv[0] = aluValid;
        rv[1] = immediateFormerValid;
        rv[2] = branchALUValid;
        others = rv[0] | rv[1] | rv[2];
        if (!reset || writebackStall) return WB_NONE;
        if (memoryValid && !(m_cnt == MAXC && others)) return WB_MEMORY;
        for (int k = 0; k < 3; k++) begin
            if (rv[(m_ptr + k) % 3]) return rr_src((m_ptr + k) % 3);
        end
        return WB_NONE;
    endfunction

    function automatic wb_source_t dut_grant();
        if (memoryReady)          return WB_MEMORY;
        if (aluReady)             return WB_ALU;
        if (immediateFormerReady) return WB_IMMEDIATE;
        if (branchALUReady)       return WB_BRANCH;
        return WB_NONE;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_ptr = 0; m_cnt = 0; m_we = 1'b0; m_idx = 0; m_data = '0;
        end else begin
            mg = model_pick();
            m_others = aluValid | immediateFormerValid | branchALUValid;
            if (!writebackStall) begin
                if (mg == WB_MEMORY) m_cnt = m_others ? m_cnt + 1 : 0;
                else m_cnt = 0;
                if (mg != WB_NONE && mg != WB_MEMORY) m_ptr = (rr_pos(mg) + 1) % 3;
            end
            if (mg != WB_NONE) begin
                m_idx  = idx_of(mg);
                m_data = rdIn;
                m_we   = (m_idx != 0);
            end else begin
                m_we = 1'b0;
            end
        end
    end

    always @(negedge clock) begin
        if (cmp_on) begin
            wb_source_t g;
            g = model_pick();
            chk("memoryReady", 32'(memoryReady), 32'(g == WB_MEMORY));
            chk("aluReady", 32'(aluReady), 32'(g == WB_ALU));
            chk("immReady", 32'(immediateFormerReady), 32'(g == WB_IMMEDIATE));
            chk("branchReady", 32'(branchALUReady), 32'(g == WB_BRANCH));
            chk("memoryOE", 32'(memoryOutputEnable), 32'(g == WB_MEMORY));
            chk("aluOE", 32'(aluOutputEnable), 32'(g == WB_ALU));
            chk("immOE", 32'(immediateFormerOutputEnable), 32'(g == WB_IMMEDIATE));
            chk("branchOE", 32'(branchALUOutputEnable), 32'(g == WB_BRANCH));
            chk("regWriteEnable", 32'(regWriteEnable), 32'(m_we));
            chk("regWriteIndex", 32'(regWriteIndex), 32'(m_idx));
            chk("regWriteData", regWriteData, m_data);
        end
    end

    task automatic clr_inputs();
        writebackStall = 1'b0;
        memoryValid = 1'b0; aluValid = 1'b0; immediateFormerValid = 1'b0; branchALUValid = 1'b0;
        memoryRdIndex = '0; aluRdIndex = '0; immediateFormerRdIndex = '0; branchALURdIndex = '0;
        rdIn = '0;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic reset_dut();
        next_cycle();
        reset = 1'b0;
        clr_inputs();
        next_cycle();
        reset = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "timeout");
    end

    initial begin
        bit         pend[4];
        logic [4:0] ridx[4];
        wb_source_t g;

        #1;
        reset  = 1'b0;
        cmp_on = 1'b1;
        clr_inputs();
        repeat (2) next_cycle();
        reset = 1'b1;

        // Basic ALU writeback.
        aluValid = 1'b1; aluRdIndex = 5'd7; rdIn = 32'h0000_1234;
        @(negedge clock);
        chk("t1_aluReady", 32'(aluReady), 32'd1);
        chk("t1_aluOE", 32'(aluOutputEnable), 32'd1);
        next_cycle();
        aluValid = 1'b0; rdIn = '0;
        @(negedge clock);
        chk("t1_we", 32'(regWriteEnable), 32'd1);
        chk("t1_idx", 32'(regWriteIndex), 32'd7);
        chk("t1_data", regWriteData, 32'h0000_1234);

        // Round-robin rotation among the three non-memory sources.
        reset_dut();
        aluValid = 1'b1; immediateFormerValid = 1'b1; branchALUValid = 1'b1;
        aluRdIndex = 5'd1; immediateFormerRdIndex = 5'd2; branchALURdIndex = 5'd3;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            chk("t2_rr_order", 32'(dut_grant()), 32'(exp_rr[i]));
            next_cycle();
        end
        clr_inputs();

        // Memory streak broken by the starvation override.
        reset_dut();
        memoryValid = 1'b1; memoryRdIndex = 5'd10;
        aluValid = 1'b1; aluRdIndex = 5'd11;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            chk("t3_starve_order", 32'(dut_grant()), 32'(exp_mem[i]));
            next_cycle();
        end
        clr_inputs();

        // Write to x0 completes but never strobes.
        reset_dut();
        memoryValid = 1'b1; memoryRdIndex = 5'd0; rdIn = 32'hDEAD_BEEF;
        @(negedge clock);
        chk("t4_memReady", 32'(memoryReady), 32'd1);
        next_cycle();
        clr_inputs();
        @(negedge clock);
        chk("t4_x0_we", 32'(regWriteEnable), 32'd0);

        // Stall blocks everything and leaves the pointer where it was.
        reset_dut();
        aluValid = 1'b1; aluRdIndex = 5'd4;
        @(negedge clock);
        chk("t5_alu_first", 32'(aluReady), 32'd1);
        next_cycle();
        writebackStall = 1'b1;
        memoryValid = 1'b1; memoryRdIndex = 5'd5;
        aluRdIndex = 5'd6;
        immediateFormerValid = 1'b1; immediateFormerRdIndex = 5'd7;
        branchALUValid = 1'b1; branchALURdIndex = 5'd8;
        @(negedge clock);
        chk("t5_stall_ready", 32'({memoryReady, aluReady, immediateFormerReady, branchALUReady}), 32'd0);
        chk("t5_stall_oe", 32'({memoryOutputEnable, aluOutputEnable, immediateFormerOutputEnable, branchALUOutputEnable}), 32'd0);
        next_cycle();
        @(negedge clock);
        chk("t5_stall_we", 32'(regWriteEnable), 32'd0);
        next_cycle();
        writebackStall = 1'b0; memoryValid = 1'b0;
        @(negedge clock);
        chk("t5_ptr_kept", 32'(dut_grant()), 32'(WB_IMMEDIATE));
        next_cycle();
        clr_inputs();

        // Reset right after a transfer discards the registered write.
        reset_dut();
        aluValid = 1'b1; aluRdIndex = 5'd9; rdIn = 32'h55AA_0F0F;
        next_cycle();
        aluValid = 1'b0;
        reset = 1'b0;
        #1;
        chk("t6_rst_we", 32'(regWriteEnable), 32'd0);
        chk("t6_rst_idx", 32'(regWriteIndex), 32'd0);
        chk("t6_rst_data", regWriteData, 32'd0);
        next_cycle();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("t6_no_strobe", 32'(regWriteEnable), 32'd0);
        end
        next_cycle();

        // Randomized traffic: requesters hold valid and index until granted.
        for (int s = 0; s < 4; s++) begin
            pend[s] = 1'b0;
            ridx[s] = '0;
        end
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            g = model_pick();
            next_cycle();
            for (int s = 0; s < 4; s++) begin
                if (pend[s] && g == src_map[s]) pend[s] = 1'b0;
                if (!pend[s] && ($urandom_range(0, 99) < ((s == 0) ? 70 : 40))) begin
                    pend[s] = 1'b1;
                    ridx[s] = 5'($urandom_range(0, 31));
                end
            end
            memoryValid = pend[0];          memoryRdIndex = ridx[0];
            aluValid = pend[1];             aluRdIndex = ridx[1];
            immediateFormerValid = pend[2]; immediateFormerRdIndex = ridx[2];
            branchALUValid = pend[3];       branchALURdIndex = ridx[3];
            writebackStall = ($urandom_range(0, 9) == 0);
            rdIn = $urandom;
        end
        clr_inputs();
        repeat (3) next_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Controller for the core's single register-file write port. Accepts writeback requests from the memory unit, ALU, immediate former and branch ALU over valid/ready handshakes. Each cycle it grants at most one request and drives the one-hot output-enable lines of the rd input chooser. It then registers the chooser's result, destination index and write enable into a one-stage writeback pipeline toward the register file.

## Interface
Parameters:
- MAX_CONSEC, 4, consecutive memory grants allowed while another requester waits (1..15)

Ports:
- clock  in  1  core clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- writebackStall  in  1  freeze: no grants while high
- memoryValid / aluValid / immediateFormerValid / branchALUValid  in  1 each  request present
- memoryRdIndex / aluRdIndex / immediateFormerRdIndex / branchALURdIndex  in  5 each  destination register, stable while valid
- memoryReady / aluReady / immediateFormerReady / branchALUReady  out  1 each  grant; transfer = valid & ready
- memoryOutputEnable / aluOutputEnable / immediateFormerOutputEnable / branchALUOutputEnable  out  1 each  one-hot (or all-zero) select to the rd chooser, equal to the matching ready
- rdIn  in  32  chooser output (rd), combinational from the enables
- regWriteEnable  out  1  registered register-file write strobe
- regWriteIndex  out  5  registered destination
- regWriteData  out  32  registered write data

## Operation
- Grant logic is combinational from valids, stall, the round-robin pointer and the starvation counter. At most one ready is high. Each enable equals its ready.
- Default priority: memory wins whenever memoryValid, unless starvation override applies.
- Others: round-robin order alu → immediateFormer → branchALU, starting at pointer. After a non-memory grant, the pointer moves to the source after the granted one. It holds otherwise.
- Starvation counter (width clog2(MAX_CONSEC+1)):
  - Increments on a memory grant while any other valid is high.
  - Clears on any non-memory grant, or on any cycle without a memory grant.
- Override: when the counter equals MAX_CONSEC and any other valid is high, memory is not granted. The round-robin winner is granted and the counter clears.
- writebackStall=1: all readies/enables 0, pointer and counter hold, and regWriteEnable is 0 the next cycle.
- On a transfer, the next edge registers regWriteIndex=granted RdIndex and regWriteData=rdIn. regWriteEnable=1 iff the index is nonzero. A write to x0 completes the handshake but never strobes.
- With no transfer, regWriteEnable=0 next cycle, and regWriteIndex/regWriteData hold their values.

## Timing
- Grant: same cycle as valid (0-cycle combinational ready). Register-file write strobe: 1 cycle after transfer.
- Throughput: one writeback per cycle.
- Reset (async assert, sync-safe deassert): regWriteEnable=0, regWriteIndex=0, regWriteData=0, pointer=alu, counter=0. Readies/enables are combinational and 0 while reset is asserted.
- Reset mid-operation discards the registered write. No strobe follows reset deassert until a new transfer.
- All four valid, counter<MAX_CONSEC: memory granted, and the others see ready=0 and must hold.
- Only memory valid: granted every cycle, and the counter stays 0.
- Stall and valid in the same cycle: the stall wins.

## Structure
- Shared package writeback_pkg:
  - enum wb_source_t {WB_NONE, WB_MEMORY, WB_ALU, WB_IMMEDIATE, WB_BRANCH}
  - localparam REG_INDEX_WIDTH=5
  - localparam XLEN=32
- One sub-module, writeback_rr_picker: 3-way round-robin pick (valids, pointer → one-hot winner, next pointer).

## Test plan
- After reset: aluValid=1, aluRdIndex=7, rdIn=32'h0000_1234 → aluReady=aluOutputEnable=1 same cycle; next cycle regWriteEnable=1, regWriteIndex=7, regWriteData=32'h0000_1234.
- aluValid, immediateFormerValid and branchALUValid held high for 6 cycles (indices 1,2,3) → grant order alu, imm, branch, alu, imm, branch.
- memoryValid and aluValid held high, MAX_CONSEC=4 → memory granted 4 cycles, alu on the 5th, then memory resumes.
- memoryValid=1, memoryRdIndex=0, rdIn=32'hDEAD_BEEF → memoryReady=1, next cycle regWriteEnable=0.
- writebackStall=1 with all valids → all readies/enables 0, regWriteEnable=0 next cycle. Deassert stall → the round-robin pointer is unchanged.
- Reset asserted one cycle after a transfer → regWriteEnable/Index/Data read 0 immediately, and there is no strobe after deassert.
